branch_target_table: RTL and testbench
======================================

BRANCH_TARGET_TABLE -- requirements
Module: branch_target_table

Interface
REQ-001 Parameter IDX_W, default 4, index width; DEPTH = 2**IDX_W entries.
REQ-002 Parameter TGT_W, default 9, target width in bits.
REQ-003 Parameter DEFAULT_TGT, default all-ones of TGT_W, target returned on miss.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 LookupValid  input  1  lookup request this cycle.
REQ-007 LookupIdx  input  IDX_W  entry to look up.
REQ-008 LookupReady  output  1  table accepts lookups (IDLE state).
REQ-009 TargetValid  output  1  one-cycle pulse: Target/Hit updated.
REQ-010 Target  output  TGT_W  looked-up target.
REQ-011 Hit  output  1  looked-up entry was valid.
REQ-012 WrEn  input  1  program one entry this cycle.
REQ-013 WrIdx  input  IDX_W  entry to program.
REQ-014 WrData  input  TGT_W  target value to program.
REQ-015 ClearReq  input  1  request invalidation of whole table.
REQ-016 Busy  output  1  clear sweep in progress.

Function
REQ-017 Storage SHALL be DEPTH entries, each a TGT_W target plus one valid bit.
REQ-018 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on ClearReq in IDLE; CLEAR->IDLE after entry DEPTH-1 is cleared.
REQ-019 CLEAR SHALL sweep one entry per cycle from index 0 upward: valid <= 0, target <= DEFAULT_TGT; the sweep lasts exactly DEPTH cycles.
REQ-020 Busy SHALL be 1 and LookupReady 0 for exactly the DEPTH cycles in CLEAR; otherwise Busy=0 and LookupReady=1.
REQ-021 A lookup SHALL be accepted when LookupValid && LookupReady; LookupValid in CLEAR SHALL be ignored and produce no response.
REQ-022 Lookup latency SHALL be 1 cycle: TargetValid=1 in the cycle after acceptance, with Target/Hit registered.
REQ-023 Hit entry SHALL return the stored target with Hit=1; an invalid entry SHALL return DEFAULT_TGT with Hit=0.
REQ-024 Target and Hit SHALL hold their last value between responses; TargetValid SHALL be 0 in cycles with no response.
REQ-025 A write in IDLE SHALL store WrData at WrIdx and set its valid bit at the clock edge.
REQ-026 Same-cycle write and lookup to the same index SHALL forward: response carries WrData with Hit=1.
REQ-027 Same-cycle write and lookup to different indices SHALL be independent.
REQ-028 WrEn in CLEAR SHALL be ignored.
REQ-029 ClearReq and WrEn in the same IDLE cycle: clear SHALL win and the write SHALL be dropped.
REQ-030 ClearReq and an accepted lookup in the same IDLE cycle: the lookup SHALL respond from pre-clear contents.
REQ-031 ClearReq during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-032 Sweep counter SHALL be IDX_W bits and wrap to 0 on leaving CLEAR.

Reset
REQ-033 Reset low SHALL immediately force IDLE, sweep counter 0, all valid bits 0, all targets DEFAULT_TGT.
REQ-034 Reset values of outputs SHALL be: Target=DEFAULT_TGT, Hit=0, TargetValid=0, Busy=0, LookupReady=1.
REQ-035 Reset asserted mid-sweep or mid-lookup SHALL abort it; no TargetValid pulse SHALL follow reset release.

Verification
REQ-036 After reset, lookup idx 3 -> next cycle TargetValid=1, Target=0x1FF, Hit=0.
REQ-037 Write idx 5 = 0x07D; next cycle lookup idx 5 -> Target=0x07D, Hit=1, one cycle latency.
REQ-038 Same cycle write idx 2 = 0x0D0 and lookup idx 2 -> next cycle Target=0x0D0, Hit=1.
REQ-039 Program idx 0..15; pulse ClearReq -> Busy=1 for 16 cycles, lookups ignored; afterwards lookup idx 15 -> 0x1FF, Hit=0.
REQ-040 ClearReq with WrEn idx 1 = 0x004 same cycle -> after sweep, lookup idx 1 -> Hit=0; ClearReq re-pulsed at sweep cycle 8 -> sweep still ends at 16.
REQ-041 Reset asserted at sweep cycle 5 -> Busy=0 immediately, all entries miss, no TargetValid after release.

Source files
------------

// File: rtl/branch_target_table.sv
// Direct-mapped branch target table with one-cycle lookup, write forwarding
// and a one-entry-per-cycle clear sweep.
module branch_target_table #(
    parameter int unsigned       IDX_W       = 4,
    parameter int unsigned       TGT_W       = 9,
    parameter logic [TGT_W-1:0]  DEFAULT_TGT = '1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_lookup_valid,
    input  logic [IDX_W-1:0] i_lookup_idx,
    output logic             o_lookup_ready,
    output logic             o_target_valid,
    output logic [TGT_W-1:0] o_target,
    output logic             o_hit,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TGT_W-1:0] i_wr_data,
    input  logic             i_clear_req,
    output logic             o_busy
);

    localparam int unsigned DEPTH = 2**IDX_W;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_cnt;
    logic [TGT_W-1:0]   r_tgt [DEPTH];
    logic [DEPTH-1:0]   r_vld;

    logic w_idle;
    logic w_lookup;
    logic w_wr;
    logic w_fwd;

    // Clear wins over a same-cycle write; lookups and writes only act in IDLE.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_lookup = i_lookup_valid && w_idle;
    assign w_wr     = i_wr_en && w_idle && !i_clear_req;
    assign w_fwd    = w_wr && (i_wr_idx == i_lookup_idx);

    // Control FSM with registered Busy/LookupReady.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            o_busy         <= 1'b0;
            o_lookup_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear_req) begin
                        r_state        <= ST_CLEAR;
                        r_cnt          <= '0;
                        o_busy         <= 1'b1;
                        o_lookup_ready <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state        <= ST_IDLE;
                        r_cnt          <= '0;
                        o_busy         <= 1'b0;
                        o_lookup_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_cnt          <= '0;
                    o_busy         <= 1'b0;
                    o_lookup_ready <= 1'b1;
                end
            endcase
        end
    end

    // Entry storage: sweep clear or single-entry program.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tgt[i] <= DEFAULT_TGT;
            end
        end else if (r_state == ST_CLEAR) begin
            r_vld[r_cnt] <= 1'b0;
            r_tgt[r_cnt] <= DEFAULT_TGT;
        end else if (w_wr) begin
            r_vld[i_wr_idx] <= 1'b1;
            r_tgt[i_wr_idx] <= i_wr_data;
        end
    end

    // Lookup response; Target/Hit hold between responses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_target_valid <= 1'b0;
            o_target       <= DEFAULT_TGT;
            o_hit          <= 1'b0;
        end else begin
            o_target_valid <= w_lookup;
            if (w_lookup) begin
                if (w_fwd) begin
                    o_target <= i_wr_data;
                    o_hit    <= 1'b1;
                end else if (r_vld[i_lookup_idx]) begin
                    o_target <= r_tgt[i_lookup_idx];
                    o_hit    <= 1'b1;
                end else begin
                    o_target <= DEFAULT_TGT;
                    o_hit    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_table.sv
// Directed self-checking bench for branch_target_table (IDX_W=4, TGT_W=9).
module tb_branch_target_table;

    logic       clk;
    logic       rst_n;
    logic       lookup_valid;
    logic [3:0] lookup_idx;
    logic       lookup_ready;
    logic       target_valid;
    logic [8:0] target;
    logic       hit;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [8:0] wr_data;
    logic       clear_req;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    branch_target_table #(.IDX_W(4), .TGT_W(9), .DEFAULT_TGT(9'h1FF)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_lookup_valid (lookup_valid),
        .i_lookup_idx   (lookup_idx),
        .o_lookup_ready (lookup_ready),
        .o_target_valid (target_valid),
        .o_target       (target),
        .o_hit          (hit),
        .i_wr_en        (wr_en),
        .i_wr_idx       (wr_idx),
        .i_wr_data      (wr_data),
        .i_clear_req    (clear_req),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input string tag, input logic [8:0] t, input logic h);
        chk({tag, "_tv"},  32'(target_valid), 32'd1);
        chk({tag, "_tgt"}, 32'(target), 32'(t));
        chk({tag, "_hit"}, 32'(hit), 32'(h));
    endtask

    initial begin
        rst_n = 1'b0; lookup_valid = 1'b0; lookup_idx = '0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; clear_req = 1'b0;
        #12;
        chk("rst_tgt",   32'(target), 32'h1FF);
        chk("rst_hit",   32'(hit), 32'd0);
        chk("rst_tv",    32'(target_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(lookup_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;

        // miss after reset
        lookup_valid = 1'b1; lookup_idx = 4'd3;
        cyc();
        resp("miss3", 9'h1FF, 1'b0);
        lookup_valid = 1'b0;
        cyc();
        chk("idle_tv", 32'(target_valid), 32'd0);
        chk("hold_tgt", 32'(target), 32'h1FF);

        // write then lookup
        wr_en = 1'b1; wr_idx = 4'd5; wr_data = 9'h07D;
        cyc();
        chk("wr_no_tv", 32'(target_valid), 32'd0);
        wr_en = 1'b0; lookup_valid = 1'b1; lookup_idx = 4'd5;
        cyc();
        resp("hit5", 9'h07D, 1'b1);

        // same-index forward
        wr_en = 1'b1; wr_idx = 4'd2; wr_data = 9'h0D0; lookup_idx = 4'd2;
        cyc();
        resp("fwd2", 9'h0D0, 1'b1);

        // different-index write and lookup are independent
        wr_idx = 4'd6; wr_data = 9'h0AA; lookup_idx = 4'd5;
        cyc();
        resp("indep5", 9'h07D, 1'b1);
        wr_en = 1'b0; lookup_idx = 4'd6;
        cyc();
        resp("indep6", 9'h0AA, 1'b1);
        lookup_valid = 1'b0;

        // program all entries with 33*i
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_idx = 4'(i); wr_data = 9'(33 * i);
            cyc();
        end
        wr_en = 1'b0;

        // clear with same-cycle lookup answers from pre-clear contents
        clear_req = 1'b1; lookup_valid = 1'b1; lookup_idx = 4'd4;
        cyc();
        resp("preclr4", 9'd132, 1'b1);
        chk("clr_busy0", 32'(busy), 32'd1);
        chk("clr_ready0", 32'(lookup_ready), 32'd0);
        clear_req = 1'b0; lookup_idx = 4'd15;
        for (int k = 1; k < 16; k++) begin
            cyc();
            chk("clr_busy", 32'(busy), 32'd1);
            chk("clr_ignored", 32'(target_valid), 32'd0);
        end
        cyc();
        chk("clr_done_busy", 32'(busy), 32'd0);
        chk("clr_done_ready", 32'(lookup_ready), 32'd1);
        chk("clr_done_tv", 32'(target_valid), 32'd0);
        cyc();
        resp("postclr15", 9'h1FF, 1'b0);
        lookup_idx = 4'd0;
        cyc();
        resp("postclr0", 9'h1FF, 1'b0);
        lookup_valid = 1'b0;

        // clear beats write; re-pulse and write during sweep are ignored
        wr_en = 1'b1; wr_idx = 4'd1; wr_data = 9'h004; clear_req = 1'b1;
        cyc();
        wr_en = 1'b0; clear_req = 1'b0;
        chk("clr2_busy0", 32'(busy), 32'd1);
        for (int k = 1; k < 16; k++) begin
            clear_req = (k == 8);
            wr_en     = (k == 8);
            wr_idx    = 4'd0;
            wr_data   = 9'h055;
            cyc();
            chk("clr2_busy", 32'(busy), 32'd1);
        end
        clear_req = 1'b0; wr_en = 1'b0;
        cyc();
        chk("clr2_end16", 32'(busy), 32'd0);
        cyc();
        chk("clr2_norestart", 32'(busy), 32'd0);
        lookup_valid = 1'b1; lookup_idx = 4'd1;
        cyc();
        resp("dropwr1", 9'h1FF, 1'b0);
        lookup_idx = 4'd0;
        cyc();
        resp("sweepwr0", 9'h1FF, 1'b0);
        lookup_valid = 1'b0;

        // reset in the middle of a sweep
        wr_en = 1'b1; wr_idx = 4'd12; wr_data = 9'h123;
        cyc();
        wr_en = 1'b0; lookup_valid = 1'b1; lookup_idx = 4'd12;
        cyc();
        resp("pre_rst12", 9'h123, 1'b1);
        lookup_valid = 1'b0; clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        for (int k = 1; k < 5; k++) cyc();
        chk("sweep5_busy", 32'(busy), 32'd1);
        lookup_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(lookup_ready), 32'd1);
        chk("rst_mid_tgt", 32'(target), 32'h1FF);
        @(negedge clk);
        lookup_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("rel_tv0", 32'(target_valid), 32'd0);
        cyc();
        chk("rel_tv1", 32'(target_valid), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
        lookup_valid = 1'b1; lookup_idx = 4'd12;
        cyc();
        resp("rst_miss12", 9'h1FF, 1'b0);
        lookup_idx = 4'd2;
        cyc();
        resp("rst_miss2", 9'h1FF, 1'b0);
        lookup_valid = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
